// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM state encoding and flag bit positions for alu_seq_top
package alu_seq_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  // o_flags = {zero, negative, carry, overflow}
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - two-flop synchroniser, debounce counter and rising-edge pulse
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      o_level <= 1'b0;
      level_q <= 1'b0;
      o_pulse <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= i_btn;
      sync_2  <= sync_1;
      level_q <= o_level;
      o_pulse <= o_level & ~level_q;
      // The level flips only after an unbroken run of disagreeing samples.
      if (sync_2 == o_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        o_level <= sync_2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq_top.sv
// rtl/alu_seq_top.sv - board ALU sequenced by a debounced ENTER button, with CLEAR,
// status flags, opcode-error detection and optional result chaining.
module alu_seq_top
  import alu_seq_pkg::*;
#(
  parameter int N_BITS          = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit CHAIN           = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_SWs,
  input  logic              i_btn_enter,
  input  logic              i_btn_clear,
  output logic [N_BITS-1:0] o_led,
  output logic [3:0]        o_flags,
  output logic              o_err,
  output logic [1:0]        o_state
);

  localparam int MSB = N_BITS - 1;

  logic              enter_pulse;
  logic              enter_level;
  logic              clear_pulse;
  logic              clear_level;
  logic              enter_go;
  state_t            state;
  state_t            state_next;
  logic [N_BITS-1:0] reg_a;
  logic [N_BITS-1:0] reg_b;
  logic [5:0]        reg_op;
  logic [5:0]        sw_op;
  logic [5:0]        alu_op;
  logic [N_BITS:0]   wide;
  logic [N_BITS-1:0] alu_res;
  logic [3:0]        alu_flags;
  logic              alu_c;
  logic              alu_v;
  logic              alu_err;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clock   (clock),
    .reset   (reset),
    .i_btn   (i_btn_enter),
    .o_level (enter_level),
    .o_pulse (enter_pulse)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock   (clock),
    .reset   (reset),
    .i_btn   (i_btn_clear),
    .o_level (clear_level),
    .o_pulse (clear_pulse)
  );

  // CLEAR wins: an ENTER edge while CLEAR is down is dropped.
  assign enter_go = enter_pulse & enter_level & ~clear_level;
  assign sw_op    = 6'(i_SWs);
  assign alu_op   = (state == WAIT_OP) ? sw_op : reg_op;
  assign o_state  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WAIT_A;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_pulse) begin
      state_next = WAIT_A;
    end else if (enter_go) begin
      case (state)
        WAIT_A:  state_next = WAIT_B;
        WAIT_B:  state_next = WAIT_OP;
        WAIT_OP: state_next = SHOW;
        SHOW:    state_next = CHAIN ? WAIT_B : WAIT_A;
      endcase
    end
  end

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (alu_op)
      OP_ADD: begin
        wide    = {1'b0, reg_a} + {1'b0, reg_b};
        alu_res = wide[MSB:0];
        alu_c   = wide[N_BITS];
        alu_v   = (reg_a[MSB] == reg_b[MSB]) && (alu_res[MSB] != reg_a[MSB]);
      end
      OP_SUB: begin
        wide    = {1'b0, reg_a} - {1'b0, reg_b};
        alu_res = wide[MSB:0];
        alu_c   = wide[N_BITS];
        alu_v   = (reg_a[MSB] != reg_b[MSB]) && (alu_res[MSB] != reg_a[MSB]);
      end
      OP_AND:  alu_res = reg_a & reg_b;
      OP_OR:   alu_res = reg_a | reg_b;
      OP_XOR:  alu_res = reg_a ^ reg_b;
      OP_NOR:  alu_res = ~(reg_a | reg_b);
      // Over-range shift amounts saturate to 0 / sign fill by operator semantics.
      OP_SRL:  alu_res = reg_a >> reg_b;
      OP_SRA:  alu_res = $unsigned($signed(reg_a) >>> reg_b);
      default: alu_err = 1'b1;
    endcase
    alu_flags = '0;
    if (!alu_err) begin
      alu_flags[FLAG_ZERO]  = (alu_res == '0);
      alu_flags[FLAG_NEG]   = alu_res[MSB];
      alu_flags[FLAG_CARRY] = alu_c;
      alu_flags[FLAG_OVF]   = alu_v;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_a   <= '0;
      reg_b   <= '0;
      reg_op  <= '0;
      o_led   <= '0;
      o_flags <= '0;
      o_err   <= 1'b0;
    end else if (clear_pulse) begin
      reg_a   <= '0;
      reg_b   <= '0;
      reg_op  <= '0;
      o_led   <= '0;
      o_flags <= '0;
      o_err   <= 1'b0;
    end else if (enter_go) begin
      case (state)
        WAIT_A:  reg_a <= i_SWs;
        WAIT_B:  reg_b <= i_SWs;
        WAIT_OP: begin
          reg_op  <= sw_op;
          o_led   <= alu_res;
          o_flags <= alu_flags;
          o_err   <= alu_err;
        end
        SHOW:    if (CHAIN) reg_a <= o_led;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_top.sv
// tb/tb_alu_seq_top.sv - table, hand-written and randomized checks of alu_seq_top
module tb_alu_seq_top;

  localparam int N    = 8;
  localparam int DB   = 4;
  localparam int HOLD = DB + 6;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sws = '0;
  logic         btn_enter = 1'b0;
  logic         btn_clear = 1'b0;
  logic [N-1:0] led1, led0;
  logic [3:0]   flags1, flags0;
  logic         err1, err0;
  logic [1:0]   state1, state0;

  int n_vec = 0;
  int n_bad = 0;

  alu_seq_top #(.N_BITS(N), .DEBOUNCE_CYCLES(DB), .CHAIN(1'b1)) u_dut (
    .clock(clock), .reset(reset), .i_SWs(sws), .i_btn_enter(btn_enter),
    .i_btn_clear(btn_clear), .o_led(led1), .o_flags(flags1), .o_err(err1), .o_state(state1)
  );

  alu_seq_top #(.N_BITS(N), .DEBOUNCE_CYCLES(DB), .CHAIN(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .i_SWs(sws), .i_btn_enter(btn_enter),
    .i_btn_clear(btn_clear), .o_led(led0), .o_flags(flags0), .o_err(err0), .o_state(state0)
  );

  always #5 clock = ~clock;

  typedef struct {
    int a;
    int b;
    int op;
    int led;
    int flags;
    int err;
  } vec_t;

  vec_t tbl[14];
  int   valid_ops[8] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h02, 'h03};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input bit chained, input int led, input int flags,
                           input int err, input int st);
    if (chained) begin
      check({tag, " led"}, 32'(led1), led);
      check({tag, " flags"}, 32'(flags1), flags);
      check({tag, " err"}, 32'(err1), err);
      check({tag, " state"}, 32'(state1), st);
    end else begin
      check({tag, " led(c0)"}, 32'(led0), led);
      check({tag, " flags(c0)"}, 32'(flags0), flags);
      check({tag, " err(c0)"}, 32'(err0), err);
      check({tag, " state(c0)"}, 32'(state0), st);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input bit ent, input bit clr);
    btn_enter = ent;
    btn_clear = clr;
    wait_cycles(HOLD);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    wait_cycles(HOLD);
  endtask

  task automatic do_op(input int a, input int b, input int op);
    sws = N'(a);
    press(1'b1, 1'b0);
    sws = N'(b);
    press(1'b1, 1'b0);
    sws = N'(op);
    press(1'b1, 1'b0);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int a, input int b, input int op,
                                output int res, output int flags, output int err);
    int sa, sb, r;
    bit c, v, ok;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; c = 0; v = 0; ok = 1;
    case (op)
      'h20: begin r = a + b; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      'h22: begin r = a - b; c = (a < b);   v = (sa - sb > 127) || (sa - sb < -128); end
      'h24: r = a & b;
      'h25: r = a | b;
      'h26: r = a ^ b;
      'h27: r = ~(a | b);
      'h02: r = (b >= N) ? 0 : (a >> b);
      'h03: r = (b >= N) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
      default: ok = 0;
    endcase
    if (!ok) begin
      res = 0; flags = 0; err = 1;
    end else begin
      res   = r & 255;
      flags = ((res == 0) ? 8 : 0) + ((res >= 128) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
      err   = 0;
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int ra, rb, rop, mres, mflags, merr;

    tbl[0]  = '{'h7F, 'h01, 'h20, 'h80, 'b0101, 0};
    tbl[1]  = '{'h05, 'h05, 'h22, 'h00, 'b1000, 0};
    tbl[2]  = '{'h03, 'h05, 'h22, 'hFE, 'b0110, 0};
    tbl[3]  = '{'h80, 'h03, 'h03, 'hF0, 'b0100, 0};
    tbl[4]  = '{'h80, 'h03, 'h02, 'h10, 'b0000, 0};
    tbl[5]  = '{'h80, 'h09, 'h03, 'hFF, 'b0100, 0};
    tbl[6]  = '{'h80, 'h09, 'h02, 'h00, 'b1000, 0};
    tbl[7]  = '{'h12, 'h34, 'h3F, 'h00, 'b0000, 1};
    tbl[8]  = '{'hF0, 'h3C, 'h24, 'h30, 'b0000, 0};
    tbl[9]  = '{'hA5, 'h5A, 'h26, 'hFF, 'b0100, 0};
    tbl[10] = '{'h0F, 'hF0, 'h27, 'h00, 'b1000, 0};
    tbl[11] = '{'h0C, 'h03, 'h25, 'h0F, 'b0000, 0};
    tbl[12] = '{'hFF, 'h01, 'h20, 'h00, 'b1010, 0};
    tbl[13] = '{'h80, 'h01, 'h22, 'h7F, 'b0001, 0};

    wait_cycles(3);
    check_dut("in reset", 1, 0, 0, 0, 0);
    reset = 1'b0;
    wait_cycles(2);
    check_dut("after reset", 1, 0, 0, 0, 0);
    check_dut("after reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      press(1'b0, 1'b1);
      do_op(tbl[i].a, tbl[i].b, tbl[i].op);
      check_dut($sformatf("tbl%0d", i), 1, tbl[i].led, tbl[i].flags, tbl[i].err, 3);
      check_dut($sformatf("tbl%0d", i), 0, tbl[i].led, tbl[i].flags, tbl[i].err, 3);
    end

    // Error then a valid op without an intervening CLEAR (CHAIN=0 instance).
    press(1'b0, 1'b1);
    do_op('h12, 'h34, 'h3F);
    check_dut("err op", 0, 0, 0, 1, 3);
    press(1'b1, 1'b0);
    check_dut("err held", 0, 0, 0, 1, 0);
    do_op('hF0, 'h3C, 'h24);
    check_dut("and clears err", 0, 'h30, 0, 0, 3);
    press(1'b1, 1'b0);
    check_dut("result held", 0, 'h30, 0, 0, 0);

    // Chain mode: result becomes operand A.
    press(1'b0, 1'b1);
    do_op('h7F, 'h01, 'h20);
    check_dut("chain first", 1, 'h80, 'b0101, 0, 3);
    press(1'b1, 1'b0);
    check_dut("chain to B", 1, 'h80, 'b0101, 0, 1);
    sws = 8'h01;
    press(1'b1, 1'b0);
    sws = 8'h20;
    press(1'b1, 1'b0);
    check_dut("chain second", 1, 'h81, 'b0100, 0, 3);

    // Asynchronous reset while in WAIT_OP.
    press(1'b1, 1'b0);
    sws = 8'h01;
    press(1'b1, 1'b0);
    check_dut("pre-reset WAIT_OP", 1, 'h81, 'b0100, 0, 2);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_dut("async reset", 1, 0, 0, 0, 0);
    check("async reset state(c0)", 32'(state0), 0);

    // Button held across reset release gives one pulse.
    btn_enter = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(30);
    check("held over reset", 32'(state1), 1);
    wait_cycles(30);
    check("held over reset once", 32'(state1), 1);
    btn_enter = 1'b0;
    wait_cycles(HOLD);

    // Glitch of DB-1 cycles is ignored; exactly DB cycles is accepted.
    press(1'b0, 1'b1);
    btn_enter = 1'b1;
    wait_cycles(DB - 1);
    btn_enter = 1'b0;
    wait_cycles(20);
    check("glitch ignored", 32'(state1), 0);
    btn_enter = 1'b1;
    wait_cycles(DB);
    btn_enter = 1'b0;
    wait_cycles(20);
    check("min press accepted", 32'(state1), 1);

    // Press latency: pulse in cycle k+DB+3, state moves on the edge after.
    press(1'b0, 1'b1);
    @(posedge clock);
    #1 btn_enter = 1'b1;
    wait_cycles(DB + 3);
    check("latency before", 32'(state1), 0);
    wait_cycles(1);
    check("latency after", 32'(state1), 1);
    wait_cycles(40);
    check("hold one step", 32'(state1), 1);
    btn_enter = 1'b0;
    wait_cycles(20);
    check("release no pulse", 32'(state1), 1);

    // ENTER and CLEAR together from SHOW: CLEAR wins.
    press(1'b0, 1'b1);
    do_op('h7F, 'h01, 'h20);
    check("pre both state", 32'(state1), 3);
    press(1'b1, 1'b1);
    check_dut("both pressed", 1, 0, 0, 0, 0);
    check_dut("both pressed", 0, 0, 0, 0, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
      rop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : valid_ops[$urandom_range(0, 7)];
      model(ra, rb, rop, mres, mflags, merr);
      press(1'b0, 1'b1);
      do_op(ra, rb, rop);
      check_dut($sformatf("rnd%0d a=%0h b=%0h op=%0h", i, ra, rb, rop), 1, mres, mflags, merr, 3);
      check_dut($sformatf("rnd%0d a=%0h b=%0h op=%0h", i, ra, rb, rop), 0, mres, mflags, merr, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_top.md
# alu_seq_top

Parametrised successor to the board-level ALU top. Takes operands and opcode from the switches through a single debounced ENTER button and a sequencing FSM, so no separate A/B/OP buttons are needed. Adds a CLEAR button, status flags, opcode-error detection and an optional chain mode that feeds the result back as operand A. Sits between the board switch/button pins and the LEDs.

## Interface

Parameters:
- N_BITS, 8, operand/result width (≥4)
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles needed to accept a new button level (≥1)
- CHAIN, 1, 1 = ENTER in SHOW reuses the result as A; 0 = ENTER in SHOW restarts at WAIT_A

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_SWs  in  N_BITS  operand / opcode switches; opcode = i_SWs[5:0]
- i_btn_enter  in  1  raw ENTER button, asynchronous to clock
- i_btn_clear  in  1  raw CLEAR button, asynchronous to clock
- o_led  out  N_BITS  result register
- o_flags  out  4  {zero, negative, carry, overflow} of the last result
- o_err  out  1  last opcode was invalid
- o_state  out  2  FSM state: WAIT_A=0, WAIT_B=1, WAIT_OP=2, SHOW=3

## Operation

- Button conditioning per button:
  - 2-FF synchroniser, then a debounce counter.
  - The debounced level takes the synced value after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement resets the counter.
  - A one-cycle pulse is generated on the debounced rising edge.
- CLEAR pulse has priority in every state: reg_A, reg_B, reg_op, o_led, o_flags and o_err all go to 0, and the FSM goes to WAIT_A.
- ENTER pulse actions by state:
  - WAIT_A: reg_A ← i_SWs, go to WAIT_B.
  - WAIT_B: reg_B ← i_SWs, go to WAIT_OP.
  - WAIT_OP: reg_op ← i_SWs[5:0]. On the same edge, o_led/o_flags/o_err take the computed values (combinational core on A, B and the switch opcode). Go to SHOW.
  - SHOW with CHAIN=1: reg_A ← o_led, go to WAIT_B.
  - SHOW with CHAIN=0: go to WAIT_A.
- The registered outputs hold their values in every state until the next WAIT_OP commit or CLEAR.
- Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011.
- Arithmetic rules:
  - Widths are modulo 2^N_BITS.
  - ADD: carry = carry-out.
  - SUB: carry = borrow, i.e. A<B unsigned.
  - overflow = signed overflow for ADD/SUB, 0 otherwise. Carry is 0 for logic ops and shifts.
  - Shift amount = reg_B, unsigned, full width. If the amount is ≥ N_BITS, SRL gives 0 and SRA gives N_BITS copies of A's MSB.
  - zero = (result==0); negative = result MSB.
- Any other opcode: result 0, flags 0, o_err=1. Valid ops clear o_err.

## Timing

- Reset values: o_led=0, o_flags=0, o_err=0, o_state=WAIT_A. Synchroniser, debounced levels and counters are 0; the internal registers (reg_A, reg_B, reg_op) are 0.
- Press latency: raw rise stable from clock edge k gives the pulse high during cycle k+DEBOUNCE_CYCLES+3, exactly one cycle wide. Releasing produces no pulse.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no pulse.
- State changes and register loads occur on the clock edge at the end of the pulse cycle; o_state updates on that same edge.
- Result latency: o_led/o_flags are valid the cycle after the WAIT_OP pulse.
- Simultaneous ENTER and CLEAR pulses: CLEAR wins and ENTER is dropped.
- Holding a button produces exactly one pulse.
- Reset asserted mid-debounce or mid-sequence: all state is immediately reset. A button already held when reset releases yields one pulse after the full latency.

## Structure

- Package alu_seq_pkg: opcode localparams, state encoding, flag bit indices.
- Sub-module btn_conditioner (parameter DEBOUNCE_CYCLES; ports clock, reset, i_btn, o_level, o_pulse), instanced twice.
- ALU core is a combinational function/always block inside alu_seq_top, driven by reg_A, reg_B and the switch opcode.

## Test plan

All scenarios use N_BITS=8, DEBOUNCE_CYCLES=4.

- A=0x7F, B=0x01, op ADD → o_led=0x80, flags: zero=0, negative=1, carry=0, overflow=1; o_err=0; o_state=SHOW.
- A=0x05, B=0x05, op SUB → 0x00, zero=1, carry=0. Then CLEAR, then A=0x03, B=0x05, SUB → 0xFE, carry=1, negative=1.
- A=0x80, B=0x03, SRA → 0xF0; SRL → 0x10. A=0x80, B=0x09, SRA → 0xFF, SRL → 0x00.
- Opcode 0x3F → o_led=0x00, o_flags=0, o_err=1. A following valid AND (0xF0 & 0x3C = 0x30) clears o_err.
- Debounce checks:
  - A 3-cycle ENTER glitch produces no state change.
  - A held ENTER advances exactly one state, with a pulse at k+7.
  - ENTER and CLEAR stable together leave the FSM in WAIT_A.
- Chain and reset:
  - CHAIN=1: result 0x80 in SHOW, ENTER moves to WAIT_B; B=0x01 with ADD gives 0x81.
  - Reset asserted while in WAIT_OP returns all outputs to 0 and the state to WAIT_A asynchronously.
